// File: rtl/ex_forward_hazard_unit.sv
// EX-stage forwarding select and load-use hazard detection.
// Keeps its own copy of the EX/MEM/WB destination records, so it only needs
// ID-stage fields from the pipeline.
module ex_forward_hazard_unit #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ID_Valid,
    input  logic [$clog2(NUM_REGS)-1:0] ID_Rs,
    input  logic [$clog2(NUM_REGS)-1:0] ID_Rt,
    input  logic                        ID_UseRs,
    input  logic                        ID_UseRt,
    input  logic                        ID_RegWrite,
    input  logic                        ID_MemRead,
    input  logic [$clog2(NUM_REGS)-1:0] ID_WriteReg,
    input  logic                        Flush,
    output logic                        ID_Stall,
    output logic [1:0]                  EX_Forwarding1,
    output logic [1:0]                  EX_Forwarding2,
    output logic [CNT_W-1:0]            StallCount
);

    localparam int unsigned RW = $clog2(NUM_REGS);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // EX stage record
    logic [RW-1:0] ex_rs_q, ex_rs_d;
    logic [RW-1:0] ex_rt_q, ex_rt_d;
    logic [RW-1:0] ex_dst_q, ex_dst_d;
    logic          ex_use_rs_q, ex_use_rs_d;
    logic          ex_use_rt_q, ex_use_rt_d;
    logic          ex_reg_write_q, ex_reg_write_d;
    logic          ex_mem_read_q, ex_mem_read_d;

    // MEM stage record
    logic [RW-1:0] mem_dst_q;
    logic          mem_reg_write_q;
    logic          mem_mem_read_q;

    // WB stage record
    logic [RW-1:0] wb_dst_q;
    logic          wb_reg_write_q;

    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    // Load-use hazard: the load in EX cannot supply its data until it reaches WB
    always_comb begin
        ID_Stall = 1'b0;
        if (ID_Valid && !Flush && ex_mem_read_q && ex_reg_write_q &&
            (ex_dst_q != '0)) begin
            if ((ID_UseRs && (ID_Rs == ex_dst_q)) ||
                (ID_UseRt && (ID_Rt == ex_dst_q))) begin
                ID_Stall = 1'b1;
            end
        end
    end

    // Next EX record: bubble on stall/flush, otherwise the ID fields gated by valid
    always_comb begin
        ex_rs_d        = '0;
        ex_rt_d        = '0;
        ex_dst_d       = '0;
        ex_use_rs_d    = 1'b0;
        ex_use_rt_d    = 1'b0;
        ex_reg_write_d = 1'b0;
        ex_mem_read_d  = 1'b0;
        if (ID_Valid && !ID_Stall && !Flush) begin
            ex_rs_d        = ID_Rs;
            ex_rt_d        = ID_Rt;
            ex_dst_d       = ID_WriteReg;
            ex_use_rs_d    = ID_UseRs;
            ex_use_rt_d    = ID_UseRt;
            ex_reg_write_d = ID_RegWrite;
            ex_mem_read_d  = ID_MemRead;
        end
    end

    // Saturating stall-cycle counter
    always_comb begin
        stall_count_d = stall_count_q;
        if (ID_Stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // Pipeline shadow registers advance every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs_q         <= '0;
            ex_rt_q         <= '0;
            ex_dst_q        <= '0;
            ex_use_rs_q     <= 1'b0;
            ex_use_rt_q     <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_dst_q       <= '0;
            mem_reg_write_q <= 1'b0;
            mem_mem_read_q  <= 1'b0;
            wb_dst_q        <= '0;
            wb_reg_write_q  <= 1'b0;
            stall_count_q   <= '0;
        end else begin
            ex_rs_q         <= ex_rs_d;
            ex_rt_q         <= ex_rt_d;
            ex_dst_q        <= ex_dst_d;
            ex_use_rs_q     <= ex_use_rs_d;
            ex_use_rt_q     <= ex_use_rt_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            mem_dst_q       <= ex_dst_q;
            mem_reg_write_q <= ex_reg_write_q;
            mem_mem_read_q  <= ex_mem_read_q;
            wb_dst_q        <= mem_dst_q;
            wb_reg_write_q  <= mem_reg_write_q;
            stall_count_q   <= stall_count_d;
        end
    end

    // Operand selects from registered state only; MEM is newer than WB,
    // and a load in MEM only holds its address so it is never a source
    always_comb begin
        EX_Forwarding1 = FWD_RF;
        EX_Forwarding2 = FWD_RF;
        if (ex_use_rs_q && (ex_rs_q != '0)) begin
            if (mem_reg_write_q && !mem_mem_read_q && (mem_dst_q == ex_rs_q)) begin
                EX_Forwarding1 = FWD_MEM;
            end else if (wb_reg_write_q && (wb_dst_q == ex_rs_q)) begin
                EX_Forwarding1 = FWD_WB;
            end
        end
        if (ex_use_rt_q && (ex_rt_q != '0)) begin
            if (mem_reg_write_q && !mem_mem_read_q && (mem_dst_q == ex_rt_q)) begin
                EX_Forwarding2 = FWD_MEM;
            end else if (wb_reg_write_q && (wb_dst_q == ex_rt_q)) begin
                EX_Forwarding2 = FWD_WB;
            end
        end
    end

    assign StallCount = stall_count_q;

endmodule

// File: tb/tb_ex_forward_hazard_unit.sv
// Self-checking bench: directed scenarios with literal expectations, then
// random traffic compared every cycle against an instruction-history model.
module tb_ex_forward_hazard_unit;

    localparam int CNT    = 8;
    localparam int CNTMAX = (1 << CNT) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ID_Valid = 1'b0;
    logic [4:0]     ID_Rs = '0;
    logic [4:0]     ID_Rt = '0;
    logic           ID_UseRs = 1'b0;
    logic           ID_UseRt = 1'b0;
    logic           ID_RegWrite = 1'b0;
    logic           ID_MemRead = 1'b0;
    logic [4:0]     ID_WriteReg = '0;
    logic           Flush = 1'b0;
    logic           ID_Stall;
    logic [1:0]     EX_Forwarding1;
    logic [1:0]     EX_Forwarding2;
    logic [CNT-1:0] StallCount;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    ex_forward_hazard_unit #(.NUM_REGS(32), .CNT_W(CNT)) dut (
        .clk(clk), .rst_n(rst_n), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt), .ID_RegWrite(ID_RegWrite),
        .ID_MemRead(ID_MemRead), .ID_WriteReg(ID_WriteReg), .Flush(Flush),
        .ID_Stall(ID_Stall), .EX_Forwarding1(EX_Forwarding1),
        .EX_Forwarding2(EX_Forwarding2), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // hist[0] = instruction in EX, hist[1] = in MEM, hist[2] = in WB
    typedef struct packed {
        logic       valid;
        logic [4:0] rs, rt, dst;
        logic       use_rs, use_rt, rw, mr;
    } instr_t;

    instr_t hist [3];
    int     m_cnt;

    function automatic bit model_stall();
        instr_t ld = hist[0];
        if (!ID_Valid || Flush) return 1'b0;
        if (!(ld.valid && ld.mr && ld.rw) || ld.dst == 0) return 1'b0;
        return (ID_UseRs && ID_Rs == ld.dst) || (ID_UseRt && ID_Rt == ld.dst);
    endfunction

    // Where the operand value lives: newest producer ahead of the consumer wins
    function automatic logic [1:0] model_fwd(input bit used, input logic [4:0] r);
        if (!hist[0].valid || !used || r == 0) return 2'd0;
        for (int age = 1; age <= 2; age++) begin
            if (hist[age].valid && hist[age].rw && hist[age].dst == r) begin
                if (age == 1 && hist[age].mr) continue;
                return (age == 1) ? 2'd2 : 2'd1;
            end
        end
        return 2'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist[0] <= '0; hist[1] <= '0; hist[2] <= '0;
            m_cnt   <= 0;
        end else begin
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            if (ID_Valid && !Flush && !model_stall())
                hist[0] <= '{valid:1'b1, rs:ID_Rs, rt:ID_Rt, dst:ID_WriteReg,
                             use_rs:ID_UseRs, use_rt:ID_UseRt, rw:ID_RegWrite, mr:ID_MemRead};
            else
                hist[0] <= '0;
            if (model_stall()) m_cnt <= (m_cnt + 1 > CNTMAX) ? CNTMAX : m_cnt + 1;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            cmp("model_fwd1", int'(EX_Forwarding1), int'(model_fwd(hist[0].use_rs, hist[0].rs)));
            cmp("model_fwd2", int'(EX_Forwarding2), int'(model_fwd(hist[0].use_rt, hist[0].rt)));
            cmp("model_stall", int'(ID_Stall), int'(model_stall()));
            cmp("model_count", int'(StallCount), m_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                      input bit rw, input bit mr, input int wd);
        ID_Valid = v; ID_Rs = 5'(rs); ID_Rt = 5'(rt); ID_UseRs = urs; ID_UseRt = urt;
        ID_RegWrite = rw; ID_MemRead = mr; ID_WriteReg = 5'(wd); Flush = 1'b0;
    endtask

    task automatic idle();
        id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_fwd1", int'(EX_Forwarding1), 0);
        cmp("reset_fwd2", int'(EX_Forwarding2), 0);
        cmp("reset_stall", int'(ID_Stall), 0);
        cmp("reset_count", int'(StallCount), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // Back-to-back: A writes $3, B reads $3 as Rs
        id(1, 1, 2, 1, 1, 1, 0, 3); tick();
        id(1, 3, 4, 1, 1, 1, 0, 8); tick();
        idle(); #1;
        cmp("b2b_fwd1", int'(EX_Forwarding1), 2);
        cmp("b2b_fwd2", int'(EX_Forwarding2), 0);
        drain();

        // Distance 2: A writes $5, unrelated, C reads $5 as Rt
        id(1, 1, 2, 1, 1, 1, 0, 5); tick();
        id(1, 1, 2, 1, 1, 1, 0, 6); tick();
        id(1, 1, 5, 1, 1, 0, 0, 0); tick();
        idle(); #1;
        cmp("dist2_fwd2", int'(EX_Forwarding2), 1);
        cmp("dist2_fwd1", int'(EX_Forwarding1), 0);
        drain();

        // Priority: middle op also writes $5
        id(1, 1, 2, 1, 1, 1, 0, 5); tick();
        id(1, 1, 2, 1, 1, 1, 0, 5); tick();
        id(1, 1, 5, 1, 1, 0, 0, 0); tick();
        idle(); #1;
        cmp("prio_fwd2", int'(EX_Forwarding2), 2);
        drain();

        // Load-use: lw $7 then add using $7
        id(1, 1, 0, 1, 0, 1, 1, 7); tick();
        id(1, 7, 2, 1, 1, 1, 0, 9); #1;
        cmp("lu_stall", int'(ID_Stall), 1);
        cmp("lu_count0", int'(StallCount), 0);
        tick();
        cmp("lu_stall_clear", int'(ID_Stall), 0);
        cmp("lu_count1", int'(StallCount), 1);
        tick();
        idle(); #1;
        cmp("lu_fwd1", int'(EX_Forwarding1), 1);
        cmp("lu_fwd2", int'(EX_Forwarding2), 0);
        drain();

        // Register 0: producer writes $0, consumer reads $0
        id(1, 1, 2, 1, 1, 1, 0, 0); tick();
        id(1, 0, 0, 1, 1, 1, 0, 4); tick();
        idle(); #1;
        cmp("r0_fwd1", int'(EX_Forwarding1), 0);
        cmp("r0_fwd2", int'(EX_Forwarding2), 0);
        drain();
        id(1, 1, 0, 1, 0, 1, 1, 0); tick();
        id(1, 0, 0, 1, 1, 1, 0, 4); #1;
        cmp("r0_nostall", int'(ID_Stall), 0);
        drain();

        // Immediate form: Rt matches MEM.dst but is not used
        id(1, 1, 2, 1, 1, 1, 0, 10); tick();
        id(1, 1, 10, 1, 0, 1, 0, 11); tick();
        idle(); #1;
        cmp("imm_fwd2", int'(EX_Forwarding2), 0);
        drain();

        // Flush during hazard
        id(1, 1, 0, 1, 0, 1, 1, 2); tick();
        id(1, 2, 2, 1, 1, 1, 0, 3); Flush = 1'b1; #1;
        cmp("flush_stall", int'(ID_Stall), 0);
        tick();
        idle(); #1;
        cmp("flush_fwd1", int'(EX_Forwarding1), 0);
        cmp("flush_fwd2", int'(EX_Forwarding2), 0);
        cmp("flush_count", int'(StallCount), 1);
        drain();

        // Asynchronous reset mid-stream while forwarding from MEM
        id(1, 1, 2, 1, 1, 1, 0, 3); tick();
        id(1, 3, 3, 1, 1, 1, 0, 8); tick();
        id(1, 1, 0, 1, 0, 1, 1, 9); #1;
        cmp("prerst_fwd1", int'(EX_Forwarding1), 2);
        #1 rst_n = 1'b0; #1;
        cmp("rst_fwd1", int'(EX_Forwarding1), 0);
        cmp("rst_fwd2", int'(EX_Forwarding2), 0);
        cmp("rst_stall", int'(ID_Stall), 0);
        cmp("rst_count", int'(StallCount), 0);
        #1 rst_n = 1'b1;
        idle(); tick(); #1;
        cmp("postrst_fwd1", int'(EX_Forwarding1), 0);
        cmp("postrst_count", int'(StallCount), 0);
        drain();

        // Random traffic over a small register range to provoke hits
        for (int n = 0; n < 2000; n++) begin
            id($urandom_range(99) < 85, $urandom_range(7), $urandom_range(7),
               $urandom_range(1), $urandom_range(1), $urandom_range(99) < 75,
               $urandom_range(99) < 35, $urandom_range(7));
            Flush = ($urandom_range(99) < 10);
            tick();
        end
        drain();

        // Saturation: reset, then force CNTMAX stalls, then one more
        rst_n = 1'b0; #2 rst_n = 1'b1;
        tick();
        for (int n = 0; n < CNTMAX; n++) begin
            id(1, 1, 0, 1, 0, 1, 1, 7); tick();
            id(1, 7, 0, 1, 0, 1, 0, 9); tick();
        end
        idle(); #1;
        cmp("sat_full", int'(StallCount), CNTMAX);
        id(1, 1, 0, 1, 0, 1, 1, 7); tick();
        id(1, 7, 0, 1, 0, 1, 0, 9); #1;
        cmp("sat_stall", int'(ID_Stall), 1);
        tick();
        cmp("sat_hold", int'(StallCount), CNTMAX);
        drain();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_forward_hazard_unit.md
# ex_forward_hazard_unit

Tracks destination registers of in-flight instructions across the EX, MEM and WB stages. Drives the 2-bit forwarding selects consumed by the EX-stage ALU operand muxes, and detects load-use hazards. On a load-use hazard it stalls ID and injects a bubble into EX. It sits beside the ID/EX pipeline register and shadows the EX/MEM/WB control state internally, so it needs only ID-stage fields and stage-advance controls.

## Interface
- NUM_REGS, 32: architectural register count; register index width is 5.
- CNT_W, 16: width of the saturating stall counter.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ID_Valid  in  1  ID holds a real instruction.
- ID_Rs  in  5  first source register.
- ID_Rt  in  5  second source register.
- ID_UseRs  in  1  instruction reads Rs.
- ID_UseRt  in  1  instruction reads Rt as an ALU operand (0 for immediate forms).
- ID_RegWrite  in  1  instruction writes a register.
- ID_MemRead  in  1  instruction is a load.
- ID_WriteReg  in  5  destination register.
- Flush  in  1  kill the ID-stage instruction (taken branch/jump).
- ID_Stall  out  1  hold PC and IF/ID; the ID/EX register loads a bubble.
- EX_Forwarding1  out  2  ALU input 1 select: 00 register file, 01 WB_WriteRegData, 10 MEM_ALUResult.
- EX_Forwarding2  out  2  ALU input 2 select, same encoding; applies to EX_ReadDataMux.
- StallCount  out  CNT_W  saturating count of stall cycles.

## Operation
- Internal stage records, cleared by reset:
  - EX: rs, rt, useRs, useRt, dst, regWrite, memRead.
  - MEM: dst, regWrite, memRead.
  - WB: dst, regWrite.
- Every cycle, WB takes MEM and MEM takes EX.
- EX loading:
  - If ID_Stall or Flush is high, EX takes a bubble: all use/regWrite/memRead bits = 0.
  - Otherwise EX takes the ID fields, gated by ID_Valid.
- Forwarding for operand 1, computed from EX.rs:
  - 10 if EX.useRs && MEM.regWrite && !MEM.memRead && MEM.dst == EX.rs && EX.rs != 0.
  - Else 01 if EX.useRs && WB.regWrite && WB.dst == EX.rs && EX.rs != 0.
  - Else 00.
  - MEM has priority over WB because it holds the newer value.
- Operand 2 uses the same rule with EX.rt/useRt.
- If useRt = 0, EX_Forwarding2 = 00, so the immediate passes through.
- A load in MEM is never a forwarding source, since MEM_ALUResult is its address. The stall rule guarantees the consumer instead sees the load in WB.
- Load-use stall: ID_Stall = ID_Valid && !Flush && EX.memRead && EX.regWrite && EX.dst != 0 && ((ID_UseRs && ID_Rs == EX.dst) || (ID_UseRt && ID_Rt == EX.dst)).
- A stall lasts exactly one cycle per hazard. Next cycle the load is in MEM and EX holds a bubble, so the condition clears.
- Same-cycle WB write and ID read of the same register are resolved by the register file (write-first), not by this block.
- Register 0 never forwards and never stalls.
- StallCount increments on each cycle with ID_Stall = 1 and saturates at all-ones.

## Timing
- Reset (asynchronous, rst_n = 0): all stage records cleared; EX_Forwarding1/2 = 00; ID_Stall = 0; StallCount = 0.
- EX_Forwarding1/2 are combinational from registered EX/MEM/WB state only. They are stable the whole cycle and glitch-free with respect to ID inputs.
- ID_Stall is combinational from the ID inputs and the EX record, with zero-cycle latency.
- Stage advance is 1 cycle per stage; there is no external enable (the pipeline never freezes EX and beyond).
- Flush and a hazard in the same cycle: Flush wins, ID_Stall = 0, and the bubble enters EX.
- Reset deasserted mid-operation: the pipeline restarts empty. No forwarding occurs until new producers reach MEM.

## Test plan
- Back-to-back ALU ops: $3 written by op A, op B reads $3 as Rs the next cycle → B in EX with A in MEM gives EX_Forwarding1 = 10, EX_Forwarding2 = 00.
- Distance-2 and priority:
  - A writes $5, an unrelated op follows, then C reads $5 as Rt → EX_Forwarding2 = 01.
  - If the middle op also writes $5 → EX_Forwarding2 = 10.
- Load-use: lw $7 followed by add using $7 → ID_Stall = 1 for exactly one cycle, StallCount 0→1. The add then enters EX with EX_Forwarding = 01.
- Register 0 and immediate:
  - Producer writes $0 with the consumer reading $0 → selects 00, no stall.
  - Consumer with ID_UseRt = 0 and ID_Rt matching MEM.dst → EX_Forwarding2 = 00.
- Flush during hazard: lw $2, then ID reads $2 with Flush = 1 → ID_Stall = 0, bubble in EX, no forwarding next cycle.
- Reset mid-stream: assert rst_n = 0 asynchronously while forwarding = 10 → outputs go to 00/0 immediately and StallCount = 0. Saturation check: force 2^CNT_W − 1 stalls, then one more → StallCount holds at all-ones.
